vedic32_seq_ctrl: RTL

Sequencing controller that computes an unsigned 32x32 product by time-sharing a single `vedic16x16` instance over four cycles. Each 16-bit half-product is shifted and summed into a 64-bit accumulator. Operands enter and the result leaves through valid/ready handshakes. The block is the area-optimised alternative to building a full combinational 32x32 Vedic tree.

---
 rtl/vedic32_seq_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vedic32_seq_ctrl.sv
// Unsigned 32x32 multiply that time-shares one vedic16x16 over four partial products.
// Result after 4 cycles (5 with PIPE_PP); in_valid/out_ready handshakes; holds Prod until taken.

module vedic2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] prod
);
   logic t0, t1, t2, c;
   assign t0 = a[1] & b[0];
   assign t1 = a[0] & b[1];
   assign t2 = a[1] & b[1];
   assign c  = t0 & t1;
   assign prod[0] = a[0] & b[0];
   assign prod[1] = t0 ^ t1;
   assign prod[2] = t2 ^ c;
   assign prod[3] = t2 & c;
endmodule

module vedic4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] prod
);
   logic [3:0] q0, q1, q2, q3;
   vedic2x2 u0 (.a(a[1:0]), .b(b[1:0]), .prod(q0));
   vedic2x2 u1 (.a(a[3:2]), .b(b[1:0]), .prod(q1));
   vedic2x2 u2 (.a(a[1:0]), .b(b[3:2]), .prod(q2));
   vedic2x2 u3 (.a(a[3:2]), .b(b[3:2]), .prod(q3));
   assign prod = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic8x8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] prod
);
   logic [7:0] q0, q1, q2, q3;
   vedic4x4 u0 (.a(a[3:0]), .b(b[3:0]), .prod(q0));
   vedic4x4 u1 (.a(a[7:4]), .b(b[3:0]), .prod(q1));
   vedic4x4 u2 (.a(a[3:0]), .b(b[7:4]), .prod(q2));
   vedic4x4 u3 (.a(a[7:4]), .b(b[7:4]), .prod(q3));
   assign prod = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

module vedic16x16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ground,
   output logic [31:0] prod,
   output logic        overflow
);
   logic [15:0] q0, q1, q2, q3;
   logic [32:0] sum;
   vedic8x8 u0 (.a(a[7:0]),  .b(b[7:0]),  .prod(q0));
   vedic8x8 u1 (.a(a[15:8]), .b(b[7:0]),  .prod(q1));
   vedic8x8 u2 (.a(a[7:0]),  .b(b[15:8]), .prod(q2));
   vedic8x8 u3 (.a(a[15:8]), .b(b[15:8]), .prod(q3));
   // ground acts as a carry-in; with it at zero the top bit can never set
   assign sum = {17'b0, q0} + {9'b0, q1, 8'b0} + {9'b0, q2, 8'b0} + {1'b0, q3, 16'b0}
              + {32'b0, ground};
   assign prod     = sum[31:0];
   assign overflow = sum[32];
endmodule

module vedic32_seq_ctrl #(
   parameter int PIPE_PP = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] Prod,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state;
   logic [1:0]  step;
   logic        drain;
   logic [31:0] a_q, b_q;
   logic [63:0] acc;
   logic [15:0] op_a, op_b;
   logic [31:0] pp;
   logic        pp_ovf;
   logic        unused_ovf;
   logic [31:0] term_pp;
   logic [1:0]  term_step;
   logic        term_vld;
   logic [63:0] term;
   logic [63:0] acc_sum;
   logic        last;
   logic        accept;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   // step bit 0 picks the A half, bit 1 picks the B half
   assign op_a = step[0] ? a_q[31:16] : a_q[15:0];
   assign op_b = step[1] ? b_q[31:16] : b_q[15:0];

   vedic16x16 u_mul (
      .a        (op_a),
      .b        (op_b),
      .ground   (1'b0),
      .prod     (pp),
      .overflow (pp_ovf)
   );
   assign unused_ovf = pp_ovf;

   generate
      if (PIPE_PP != 0) begin : g_pipe
         logic [31:0] pp_q;
         logic [1:0]  step_q;
         logic        vld_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pp_q   <= '0;
               step_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               pp_q   <= pp;
               step_q <= step;
               vld_q  <= (state == MUL) && !drain;
            end
         end
         assign term_pp   = pp_q;
         assign term_step = step_q;
         assign term_vld  = vld_q;
      end else begin : g_comb
         assign term_pp   = pp;
         assign term_step = step;
         assign term_vld  = (state == MUL);
      end
   endgenerate

   always_comb begin
      term = 64'b0;
      case (term_step)
         2'd0:    term = {32'b0, term_pp};
         2'd1,
         2'd2:    term = {16'b0, term_pp, 16'b0};
         default: term = {term_pp, 32'b0};
      endcase
   end

   assign acc_sum = acc + term;
   // the pipelined variant finishes on the drain cycle after the last issue
   assign last    = (state == MUL) && ((PIPE_PP != 0) ? drain : (step == 2'd3));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= 2'd0;
         drain     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         Prod      <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (accept) begin
         a_q       <= A;
         b_q       <= B;
         acc       <= '0;
         step      <= 2'd0;
         drain     <= 1'b0;
         state     <= MUL;
         out_valid <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            MUL: begin
               if (term_vld)
                  acc <= acc_sum;
               if (last) begin
                  Prod      <= acc_sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (step == 2'd3) begin
                  drain <= 1'b1;
               end else begin
                  step <= step + 2'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
